// File: rtl/eth_tx_frame_arbiter_if.sv
// Handshake/bus bundle for eth_tx_frame_arbiter: per-requester header+payload in, shared port out.
// frame_count exists only when ETH_TX_ARB_STATS_EN is defined.
interface eth_tx_frame_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_hdr_valid;
  logic [NUM_REQ-1:0]            req_hdr_ready;
  logic [48*NUM_REQ-1:0]         req_dest_mac;
  logic [48*NUM_REQ-1:0]         req_src_mac;
  logic [16*NUM_REQ-1:0]         req_type;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_tdata;
  logic [NUM_REQ-1:0]            req_tvalid;
  logic [NUM_REQ-1:0]            req_tlast;
  logic [NUM_REQ-1:0]            req_tuser;
  logic [NUM_REQ-1:0]            req_tready;

  logic                  m_eth_hdr_valid;
  logic                  m_eth_hdr_ready;
  logic [47:0]           m_eth_dest_mac;
  logic [47:0]           m_eth_src_mac;
  logic [15:0]           m_eth_type;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tuser;
  logic                  m_tready;

  logic                  grant_valid;
  logic [GW-1:0]         grant_id;
`ifdef ETH_TX_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] frame_count;
`endif

  modport master (
    input  req_hdr_valid, req_dest_mac, req_src_mac, req_type,
           req_tdata, req_tvalid, req_tlast, req_tuser,
           m_eth_hdr_ready, m_tready,
    output req_hdr_ready, req_tready,
           m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_tdata, m_tvalid, m_tlast, m_tuser,
`ifdef ETH_TX_ARB_STATS_EN
           frame_count,
`endif
           grant_valid, grant_id
  );

  modport slave (
    output req_hdr_valid, req_dest_mac, req_src_mac, req_type,
           req_tdata, req_tvalid, req_tlast, req_tuser,
           m_eth_hdr_ready, m_tready,
    input  req_hdr_ready, req_tready,
           m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_tdata, m_tvalid, m_tlast, m_tuser,
`ifdef ETH_TX_ARB_STATS_EN
           frame_count,
`endif
           grant_valid, grant_id
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin per-frame arbiter sharing one eth header+payload port between NUM_REQ sources.
// Define ETH_TX_ARB_STATS_EN to add per-requester frame counters (bus.frame_count).
module eth_tx_frame_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_tx_frame_arbiter_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, pick, idx;
  logic          found, hdr_hs, last_hs;

  logic [NUM_REQ-1:0][47:0]           dest_a, src_a;
  logic [NUM_REQ-1:0][15:0]           type_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;

  assign dest_a = bus.req_dest_mac;
  assign src_a  = bus.req_src_mac;
  assign type_a = bus.req_type;
  assign data_a = bus.req_tdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_hdr_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign hdr_hs  = (state_q == HDR) && bus.req_hdr_valid[gnt_q] && bus.m_eth_hdr_ready;
  assign last_hs = (state_q == PAYLOAD) && bus.req_tvalid[gnt_q] &&
                   bus.req_tlast[gnt_q] && bus.m_tready;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: if (found) begin
        gnt_d   = pick;
        state_d = HDR;
      end
      HDR: if (hdr_hs) state_d = PAYLOAD;
      PAYLOAD: if (last_hs) begin
        rr_ptr_d = GW'((int'(gnt_q) + 1) % NUM_REQ);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data fields always follow the grant mux; only valids/readies are state-gated.
  always_comb begin
    bus.m_eth_dest_mac  = dest_a[gnt_q];
    bus.m_eth_src_mac   = src_a[gnt_q];
    bus.m_eth_type      = type_a[gnt_q];
    bus.m_tdata         = data_a[gnt_q];
    bus.m_eth_hdr_valid = 1'b0;
    bus.m_tvalid        = 1'b0;
    bus.m_tlast         = 1'b0;
    bus.m_tuser         = 1'b0;
    bus.req_hdr_ready   = '0;
    bus.req_tready      = '0;
    bus.grant_valid     = (state_q != IDLE);
    bus.grant_id        = gnt_q;
    if (state_q == HDR) begin
      bus.m_eth_hdr_valid      = bus.req_hdr_valid[gnt_q];
      bus.req_hdr_ready[gnt_q] = bus.m_eth_hdr_ready;
    end
    if (state_q == PAYLOAD) begin
      bus.m_tvalid          = bus.req_tvalid[gnt_q];
      bus.m_tlast           = bus.req_tlast[gnt_q];
      bus.m_tuser           = bus.req_tuser[gnt_q];
      bus.req_tready[gnt_q] = bus.m_tready;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (last_hs) cnt_q[gnt_q] <= cnt_q[gnt_q] + 16'd1;
  end

  assign bus.frame_count = cnt_q;
`endif
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: cycle vector table plus source-model sequences.
module tb_eth_tx_frame_arbiter;
  localparam int NR = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_frame_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
  eth_tx_frame_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] hv, tv, tl;
    logic [7:0] d0, d1;
    logic       mhr, mtr;
    logic       e_hv, e_tv, e_tl;
    logic [7:0] e_d;
    logic       e_gv, e_gid;
    logic [1:0] e_hr, e_tr;
    logic [15:0] e_type;
  } vec_t;

  vec_t tbl[14];
  logic [1:0][47:0] dest_c;
  logic [1:0][7:0]  td;
  logic [1:0]       tu;

  // Source model state: ph 0=idle 1=header 2=payload
  int ph[2], beat[2], nfr[2], len[2];
  int grant_log[$];
  int beats_seen;
  logic prev_last;

  task automatic drive_src();
    for (int i = 0; i < 2; i++) begin
      bus.req_hdr_valid[i] = (ph[i] == 1);
      bus.req_tvalid[i]    = (ph[i] == 2);
      bus.req_tlast[i]     = (ph[i] == 2) && (beat[i] == len[i] - 1);
      td[i]                = 8'(i * 64 + beat[i]);
      tu[i]                = 1'(beat[i] & 1);
    end
    bus.req_tdata = td;
    bus.req_tuser = tu;
  endtask

  task automatic cycle(input bit rand_rdy);
    logic [1:0] oh, hh, dh;
    int g;
    bus.m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_src();
    @(negedge clk);
    g  = int'(bus.grant_id);
    oh = 2'b01 << bus.grant_id;
    if (prev_last) chk("gap_hdr_valid", 64'(bus.m_eth_hdr_valid), 64'(0));
    chk("nongrant_ready", 64'({bus.req_hdr_ready & ~oh, bus.req_tready & ~oh}), 64'(0));
    if (bus.m_tvalid) chk("tready_pass", 64'(bus.req_tready[g]), 64'(bus.m_tready));
    if (bus.m_eth_hdr_valid && bus.m_eth_hdr_ready) grant_log.push_back(g);
    if (bus.m_tvalid && bus.m_tready) begin
      chk("beat_data", 64'(bus.m_tdata), 64'(8'(g * 64 + beat[g])));
      chk("beat_last", 64'(bus.m_tlast), 64'(beat[g] == len[g] - 1));
      chk("beat_user", 64'(bus.m_tuser), 64'(beat[g] & 1));
      beats_seen++;
    end
    hh = bus.req_hdr_valid & bus.req_hdr_ready;
    dh = bus.req_tvalid & bus.req_tready;
    prev_last = bus.m_tvalid && bus.m_tready && bus.m_tlast;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hh[i]) begin
        ph[i] = 2; beat[i] = 0;
      end else if (dh[i]) begin
        if (beat[i] == len[i] - 1) begin
          nfr[i]--; beat[i] = 0; ph[i] = (nfr[i] > 0) ? 1 : 0;
        end else beat[i]++;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; beat[i] = 0; nfr[i] = 0; len[i] = 1;
    end
    prev_last = 1'b0;
    drive_src();
  endtask

  task automatic do_reset();
    clear_src();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[6];
    bit done;
    dest_c = {48'h112233445566, 48'h0A0B0C0D0E0F};
    bus.req_dest_mac = dest_c;
    bus.req_src_mac  = {48'hAABBCCDDEE01, 48'hAABBCCDDEE00};
    bus.req_type     = {16'h86DD, 16'h0800};
    bus.m_eth_hdr_ready = 1'b1;
    bus.m_tready        = 1'b1;
    clear_src();

    //            hv    tv    tl    d0     d1     mhr mtr  ehv etv etl ed     egv gid ehr   etr   type
    tbl[0]  = '{2'b01,2'b00,2'b00,8'h00,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,2'b00,2'b00,16'h0800};
    tbl[1]  = '{2'b01,2'b00,2'b00,8'h00,8'h00,1'b1,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,2'b01,2'b00,16'h0800};
    tbl[2]  = '{2'b00,2'b01,2'b00,8'h11,8'h00,1'b1,1'b1, 1'b0,1'b1,1'b0,8'h11,1'b1,1'b0,2'b00,2'b01,16'h0800};
    tbl[3]  = '{2'b00,2'b01,2'b00,8'h22,8'h00,1'b1,1'b1, 1'b0,1'b1,1'b0,8'h22,1'b1,1'b0,2'b00,2'b01,16'h0800};
    tbl[4]  = '{2'b00,2'b01,2'b00,8'h33,8'h00,1'b1,1'b1, 1'b0,1'b1,1'b0,8'h33,1'b1,1'b0,2'b00,2'b01,16'h0800};
    tbl[5]  = '{2'b00,2'b01,2'b01,8'h44,8'h00,1'b1,1'b1, 1'b0,1'b1,1'b1,8'h44,1'b1,1'b0,2'b00,2'b01,16'h0800};
    tbl[6]  = '{2'b10,2'b00,2'b00,8'h00,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,2'b00,2'b00,16'h0800};
    tbl[7]  = '{2'b10,2'b10,2'b00,8'h00,8'h55,1'b0,1'b1, 1'b1,1'b0,1'b0,8'h55,1'b1,1'b1,2'b00,2'b00,16'h86DD};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{2'b10,2'b10,2'b00,8'h00,8'h55,1'b1,1'b1, 1'b1,1'b0,1'b0,8'h55,1'b1,1'b1,2'b10,2'b00,16'h86DD};
    tbl[11] = '{2'b00,2'b10,2'b10,8'h00,8'h55,1'b1,1'b0, 1'b0,1'b1,1'b1,8'h55,1'b1,1'b1,2'b00,2'b00,16'h86DD};
    tbl[12] = '{2'b00,2'b10,2'b10,8'h00,8'h55,1'b1,1'b1, 1'b0,1'b1,1'b1,8'h55,1'b1,1'b1,2'b00,2'b10,16'h86DD};
    tbl[13] = '{2'b00,2'b00,2'b00,8'h00,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,2'b00,2'b00,16'h86DD};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant_valid", 64'(bus.grant_valid), 64'(0));
    chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
    chk("rst_valids", 64'({bus.m_eth_hdr_valid, bus.m_tvalid, bus.m_tlast, bus.m_tuser}), 64'(0));
    chk("rst_readies", 64'({bus.req_hdr_ready, bus.req_tready}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      bus.req_hdr_valid   = tbl[v].hv;
      bus.req_tvalid      = tbl[v].tv;
      bus.req_tlast       = tbl[v].tl;
      bus.req_tuser       = 2'b00;
      td                  = {tbl[v].d1, tbl[v].d0};
      bus.req_tdata       = td;
      bus.m_eth_hdr_ready = tbl[v].mhr;
      bus.m_tready        = tbl[v].mtr;
      @(negedge clk);
      chk($sformatf("v%0d_hdr_valid", v), 64'(bus.m_eth_hdr_valid), 64'(tbl[v].e_hv));
      chk($sformatf("v%0d_tvalid", v), 64'(bus.m_tvalid), 64'(tbl[v].e_tv));
      chk($sformatf("v%0d_tlast", v), 64'(bus.m_tlast), 64'(tbl[v].e_tl));
      chk($sformatf("v%0d_tdata", v), 64'(bus.m_tdata), 64'(tbl[v].e_d));
      chk($sformatf("v%0d_grant_valid", v), 64'(bus.grant_valid), 64'(tbl[v].e_gv));
      chk($sformatf("v%0d_grant_id", v), 64'(bus.grant_id), 64'(tbl[v].e_gid));
      chk($sformatf("v%0d_hdr_ready", v), 64'(bus.req_hdr_ready), 64'(tbl[v].e_hr));
      chk($sformatf("v%0d_tready", v), 64'(bus.req_tready), 64'(tbl[v].e_tr));
      chk($sformatf("v%0d_type", v), 64'(bus.m_eth_type), 64'(tbl[v].e_type));
      chk($sformatf("v%0d_dest", v), 64'(bus.m_eth_dest_mac), 64'(dest_c[tbl[v].e_gid]));
      @(posedge clk);
      #1;
    end

    // Both request together, each re-requests right after its own frame.
    bus.m_eth_hdr_ready = 1'b1;
    do_reset();
    ph[0] = 1; nfr[0] = 3; len[0] = 3;
    ph[1] = 1; nfr[1] = 3; len[1] = 2;
    grant_log.delete();
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      cycle(1'b0);
      done = (ph[0] == 0) && (ph[1] == 0);
    end
    chk("alt_done", 64'(done), 64'(1));
    exp_order = '{0, 1, 0, 1, 0, 1};
    chk("alt_count", 64'(grant_log.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) chk($sformatf("alt_grant%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

    // 16-beat frame from req1 under random downstream backpressure.
    ph[1] = 1; nfr[1] = 1; len[1] = 16; beat[1] = 0;
    beats_seen = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      cycle(1'b1);
      done = (ph[1] == 0);
    end
    chk("bp_done", 64'(done), 64'(1));
    chk("bp_beats", 64'(beats_seen), 64'(16));
`ifdef ETH_TX_ARB_STATS_EN
    chk("stats_req0", 64'(bus.frame_count[15:0]), 64'(3));
    chk("stats_req1", 64'(bus.frame_count[31:16]), 64'(4));
`endif

    // Reset asserted in the middle of a req1 payload.
    ph[1] = 1; nfr[1] = 1; len[1] = 8; beat[1] = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      cycle(1'b0);
      done = (ph[1] == 2) && (beat[1] >= 3);
    end
    chk("mid_reached", 64'(done), 64'(1));
    drive_src();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_grant_valid", 64'(bus.grant_valid), 64'(0));
    chk("mid_grant_id", 64'(bus.grant_id), 64'(0));
    chk("mid_valids", 64'({bus.m_eth_hdr_valid, bus.m_tvalid, bus.m_tlast}), 64'(0));
    chk("mid_readies", 64'({bus.req_hdr_ready, bus.req_tready}), 64'(0));
`ifdef ETH_TX_ARB_STATS_EN
    chk("mid_stats", 64'(bus.frame_count), 64'(0));
`endif
    @(posedge clk);
    #1;
    clear_src();
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
